// File: rtl/fifo_refill_pkg.sv
// Shared definitions for the FIFO refill controller: FSM state encoding,
// default burst/address geometry and a helper for sizing the beat counter.
package fifo_refill_pkg;

    localparam int DEF_BURST_LEN = 8;
    localparam int DEF_ADDR_W    = 24;
    localparam int DATA_W        = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } refill_state_t;

    // Width of a counter that must hold 0 .. burst_len-1 (never below 1 bit).
    function automatic int beat_cnt_w(input int burst_len);
        return (burst_len > 1) ? $clog2(burst_len) : 1;
    endfunction

endpackage

// File: rtl/fifo_refill_ctrl_if.sv
// Memory read-burst bus between the refill controller and the memory port.
//   mem_req    : burst request, held until mem_ack
//   mem_addr   : burst start word address, valid while mem_req=1
//   mem_ack    : request accepted
//   mem_rvalid : read data strobe
//   mem_rdata  : read data word
// master = controller side, slave = memory side.
interface fifo_refill_if
    import fifo_refill_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rvalid,
        output mem_rdata
    );

endinterface

// File: rtl/fifo_refill_ctrl_addr_gen.sv
// refill_addr_gen: owns the running read offset inside the source region.
//   clk143, reset : clock and synchronous active-high reset
//   load          : one-cycle strobe on IDLE->REQ; captures base_addr and
//                   frame_words and forms the burst start address
//   advance       : one-cycle strobe on the final beat of a burst
//   base_addr     : region start word address
//   frame_words   : region length in words (multiple of BURST_LEN)
//   mem_addr      : burst start address, stable from REQ entry onward
//   wrap_pulse    : one-cycle pulse when the offset wraps back to 0
module refill_addr_gen
    import fifo_refill_pkg::*;
#(
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic              clk143,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] frame_words,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              wrap_pulse
);

    localparam logic [ADDR_W:0] BURST_STEP = (ADDR_W+1)'(BURST_LEN);

    logic [ADDR_W-1:0] word_ofs;
    logic [ADDR_W-1:0] frame_q;
    logic [ADDR_W:0]   ofs_sum;
    logic              ofs_wraps;

    // One extra bit so an offset near 2^ADDR_W cannot overflow past the
    // frame compare.
    assign ofs_sum   = {1'b0, word_ofs} + BURST_STEP;
    assign ofs_wraps = (ofs_sum >= {1'b0, frame_q});

    // base_addr/frame_words are sampled only at REQ entry so that a
    // mid-burst reconfiguration cannot move the address being requested.
    // The offset itself is kept as-is when the frame changes.
    always_ff @(posedge clk143) begin
        if (reset) begin
            word_ofs   <= '0;
            frame_q    <= '0;
            mem_addr   <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            if (load) begin
                mem_addr <= base_addr + word_ofs;
                frame_q  <= frame_words;
            end
            if (advance) begin
                if (ofs_wraps) begin
                    word_ofs   <= '0;
                    wrap_pulse <= 1'b1;
                end else begin
                    word_ofs <= ofs_sum[ADDR_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/fifo_refill_ctrl.sv
// fifo_refill_ctrl: keeps a downstream FIFO topped up by issuing fixed-length
// read bursts over a circular source region.
//   clk143, reset : clock and synchronous active-high reset
//   enable        : permits new bursts
//   base_addr     : region start word address
//   frame_words   : region length in words
//   buf_hw/buf_lw : downstream FIFO high/low watermarks
//   mem_bus       : memory burst bus (master side)
//   fifo_we       : FIFO write strobe, one cycle after each accepted beat
//   fifo_din      : FIFO write data, holds when fifo_we=0
//   busy          : high whenever the FSM is not IDLE
//   wrap_pulse    : one-cycle pulse when the read offset wraps to 0
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no burst in flight; start one when enabled and filling
// REQ   | mem_req raised with a stable mem_addr, waiting for mem_ack
// DATA  | collecting BURST_LEN beats; cannot be aborted except by reset
module fifo_refill_ctrl
    import fifo_refill_pkg::*;
#(
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic              clk143,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] frame_words,
    input  logic              buf_hw,
    input  logic              buf_lw,
    fifo_refill_if.master     mem_bus,
    output logic              fifo_we,
    output logic [DATA_W-1:0] fifo_din,
    output logic              busy,
    output logic              wrap_pulse
);

    localparam int                BEAT_W    = beat_cnt_w(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    refill_state_t     state;
    refill_state_t     state_nxt;
    logic              fill_active;
    logic [BEAT_W-1:0] beat_cnt;
    logic              start_burst;
    logic              beat_take;
    logic              last_beat;
    logic [ADDR_W-1:0] burst_addr;

    assign start_burst = (state == IDLE) && enable && fill_active;
    assign beat_take   = (state == DATA) && mem_bus.mem_rvalid;
    assign last_beat   = beat_take && (beat_cnt == LAST_BEAT);

    // Watermark hysteresis: high watermark wins when both are asserted.
    always_ff @(posedge clk143) begin
        if (reset) begin
            fill_active <= 1'b0;
        end else if (buf_hw) begin
            fill_active <= 1'b0;
        end else if (buf_lw) begin
            fill_active <= 1'b1;
        end
    end

    always_ff @(posedge clk143) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // buf_hw/enable only gate IDLE->REQ; a started burst runs to completion.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_burst)         state_nxt = REQ;
            REQ:  if (mem_bus.mem_ack)     state_nxt = DATA;
            DATA: if (last_beat)           state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_bus.mem_req = 1'b0;
        busy            = 1'b0;
        case (state)
            IDLE: begin
                mem_bus.mem_req = 1'b0;
                busy            = 1'b0;
            end
            REQ: begin
                mem_bus.mem_req = 1'b1;
                busy            = 1'b1;
            end
            DATA: begin
                mem_bus.mem_req = 1'b0;
                busy            = 1'b1;
            end
            default: begin
                mem_bus.mem_req = 1'b0;
                busy            = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk143) begin
        if (reset) begin
            beat_cnt <= '0;
        end else if ((state == REQ) && mem_bus.mem_ack) begin
            beat_cnt <= '0;
        end else if (beat_take) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
        end
    end

    // Registered write path: the final beat's write lands in the first IDLE
    // cycle, which is the only fifo_we seen outside DATA.
    always_ff @(posedge clk143) begin
        if (reset) begin
            fifo_we  <= 1'b0;
            fifo_din <= '0;
        end else begin
            fifo_we <= beat_take;
            if (beat_take) begin
                fifo_din <= mem_bus.mem_rdata;
            end
        end
    end

    refill_addr_gen #(
        .BURST_LEN (BURST_LEN),
        .ADDR_W    (ADDR_W)
    ) u_addr_gen (
        .clk143      (clk143),
        .reset       (reset),
        .load        (start_burst),
        .advance     (last_beat),
        .base_addr   (base_addr),
        .frame_words (frame_words),
        .mem_addr    (burst_addr),
        .wrap_pulse  (wrap_pulse)
    );

    assign mem_bus.mem_addr = burst_addr;

endmodule

// File: tb/tb_fifo_refill_ctrl.sv
`timescale 1ns/1ps
module tb_fifo_refill_ctrl;

    localparam int BURST_LEN = 8;
    localparam int ADDR_W    = 24;

    logic              clk143 = 1'b0;
    logic              reset;
    logic              enable;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] frame_words;
    logic              buf_hw;
    logic              buf_lw;
    logic              fifo_we;
    logic [15:0]       fifo_din;
    logic              busy;
    logic              wrap_pulse;

    fifo_refill_if #(.ADDR_W(ADDR_W)) mem_bus ();

    fifo_refill_ctrl #(
        .BURST_LEN (BURST_LEN),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk143      (clk143),
        .reset       (reset),
        .enable      (enable),
        .base_addr   (base_addr),
        .frame_words (frame_words),
        .buf_hw      (buf_hw),
        .buf_lw      (buf_lw),
        .mem_bus     (mem_bus),
        .fifo_we     (fifo_we),
        .fifo_din    (fifo_din),
        .busy        (busy),
        .wrap_pulse  (wrap_pulse)
    );

    always #5 clk143 = ~clk143;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [15:0] wr_data[$];
    int          wr_cyc[$];
    int          beat_cyc[$];

    always @(posedge clk143) cyc <= cyc + 1;

    always @(negedge clk143) begin
        if (fifo_we === 1'b1) begin
            wr_data.push_back(fifo_din);
            wr_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk143);
        #1;
    endtask

    task automatic clear_logs();
        wr_data.delete();
        wr_cyc.delete();
        beat_cyc.delete();
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        enable             = 1'b0;
        buf_hw             = 1'b0;
        buf_lw             = 1'b0;
        mem_bus.mem_ack    = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic fill_pulse();
        buf_lw = 1'b1;
        tick();
        buf_lw = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_bus.mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic ack_now();
        mem_bus.mem_ack = 1'b1;
        tick();
        mem_bus.mem_ack = 1'b0;
    endtask

    // gap = idle cycles inserted between consecutive beats
    task automatic send_beats(input logic [15:0] first, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            mem_bus.mem_rvalid = 1'b1;
            mem_bus.mem_rdata  = first + 16'(i);
            beat_cyc.push_back(cyc);
            tick();
            mem_bus.mem_rvalid = 1'b0;
            if (i != n - 1) repeat (gap) tick();
        end
    endtask

    task automatic test_reset();
        reset              = 1'b1;
        enable             = 1'b1;
        buf_lw             = 1'b1;
        buf_hw             = 1'b0;
        mem_bus.mem_ack    = 1'b1;
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 16'h1234;
        base_addr          = 24'h001000;
        frame_words        = 24'd16;
        tick();
        tick();
        tests_run++;
        if ({mem_bus.mem_req, fifo_we, busy, wrap_pulse} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_outputs: req/we/busy/wrap=%b expected 0000",
                     {mem_bus.mem_req, fifo_we, busy, wrap_pulse});
        end
        tests_run++;
        if (fifo_din !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_fifo_din: got %h expected 0000", fifo_din);
        end
        do_reset();
    endtask

    task automatic test_basic_burst();
        bit ok;
        bit unstable;
        do_reset();
        clear_logs();
        base_addr   = 24'h001000;
        frame_words = 24'd16;
        enable      = 1'b1;
        fill_pulse();
        wait_req(ok);
        tests_run++;
        if (ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_req_timeout: mem_req=%b expected 1", mem_bus.mem_req);
        end
        tests_run++;
        if (mem_bus.mem_addr !== 24'h001000) begin
            tests_failed++;
            $display("FAIL basic_addr: got %h expected 001000", mem_bus.mem_addr);
        end
        unstable = 1'b0;
        repeat (3) begin
            tick();
            if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 24'h001000) unstable = 1'b1;
        end
        tests_run++;
        if (unstable !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_req_hold: req/addr changed before ack, req=%b addr=%h",
                     mem_bus.mem_req, mem_bus.mem_addr);
        end
        enable = 1'b0;
        ack_now();
        tests_run++;
        if ({mem_bus.mem_req, busy} !== 2'b01) begin
            tests_failed++;
            $display("FAIL basic_data_entry: req/busy=%b expected 01", {mem_bus.mem_req, busy});
        end
        send_beats(16'hA000, 8, 0);
        tests_run++;
        if ({busy, wrap_pulse} !== 2'b00) begin
            tests_failed++;
            $display("FAIL basic_end_idle: busy/wrap=%b expected 00", {busy, wrap_pulse});
        end
        tick();
        tick();
        tests_run++;
        if (wr_data.size() != 8) begin
            tests_failed++;
            $display("FAIL basic_write_count: got %0d expected 8", wr_data.size());
        end
        for (int i = 0; i < 8 && i < wr_data.size(); i++) begin
            tests_run++;
            if (wr_data[i] !== 16'hA000 + 16'(i) || wr_cyc[i] != beat_cyc[i] + 1) begin
                tests_failed++;
                $display("FAIL basic_write_%0d: data %h at cyc %0d expected %h at cyc %0d",
                         i, wr_data[i], wr_cyc[i], 16'hA000 + 16'(i), beat_cyc[i] + 1);
            end
        end
        tests_run++;
        if ({mem_bus.mem_req, busy, fifo_we} !== 3'b000) begin
            tests_failed++;
            $display("FAIL basic_stay_idle: req/busy/we=%b expected 000",
                     {mem_bus.mem_req, busy, fifo_we});
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [ADDR_W-1:0] exp_addr;
        logic exp_wrap;
        do_reset();
        clear_logs();
        base_addr   = 24'h001000;
        frame_words = 24'd16;
        enable      = 1'b1;
        fill_pulse();
        for (int b = 0; b < 3; b++) begin
            exp_addr = (b == 1) ? 24'h001008 : 24'h001000;
            exp_wrap = (b == 1);
            wait_req(ok);
            tests_run++;
            if (ok !== 1'b1 || mem_bus.mem_addr !== exp_addr) begin
                tests_failed++;
                $display("FAIL wrap_addr_b%0d: req=%b addr=%h expected req 1 addr %h",
                         b, mem_bus.mem_req, mem_bus.mem_addr, exp_addr);
            end
            ack_now();
            if (b == 2) enable = 1'b0;
            send_beats(16'hB000 + 16'(b * 16), 8, 0);
            tests_run++;
            if (wrap_pulse !== exp_wrap) begin
                tests_failed++;
                $display("FAIL wrap_pulse_b%0d: got %b expected %b", b, wrap_pulse, exp_wrap);
            end
            tick();
            tests_run++;
            if (wrap_pulse !== 1'b0) begin
                tests_failed++;
                $display("FAIL wrap_pulse_width_b%0d: got %b expected 0", b, wrap_pulse);
            end
        end
    endtask

    task automatic test_hw_stop();
        bit ok;
        int n_req;
        do_reset();
        clear_logs();
        base_addr   = 24'h001000;
        frame_words = 24'd16;
        enable      = 1'b1;
        fill_pulse();
        wait_req(ok);
        ack_now();
        send_beats(16'hC000, 4, 0);
        buf_hw = 1'b1;
        send_beats(16'hC004, 4, 0);
        tick();
        tick();
        tests_run++;
        if (wr_data.size() != 8) begin
            tests_failed++;
            $display("FAIL hw_write_count: got %0d expected 8", wr_data.size());
        end
        for (int i = 0; i < 8 && i < wr_data.size(); i++) begin
            tests_run++;
            if (wr_data[i] !== 16'hC000 + 16'(i)) begin
                tests_failed++;
                $display("FAIL hw_write_%0d: got %h expected %h", i, wr_data[i], 16'hC000 + 16'(i));
            end
        end
        n_req = 0;
        repeat (10) begin
            if (mem_bus.mem_req !== 1'b0) n_req++;
            tick();
        end
        tests_run++;
        if (n_req != 0) begin
            tests_failed++;
            $display("FAIL hw_block_req: %0d request cycles expected 0", n_req);
        end
        buf_hw = 1'b0;
        n_req  = 0;
        repeat (10) begin
            if (mem_bus.mem_req !== 1'b0) n_req++;
            tick();
        end
        tests_run++;
        if (n_req != 0) begin
            tests_failed++;
            $display("FAIL hw_hysteresis: %0d request cycles expected 0", n_req);
        end
        fill_pulse();
        wait_req(ok);
        tests_run++;
        if (ok !== 1'b1 || mem_bus.mem_addr !== 24'h001008) begin
            tests_failed++;
            $display("FAIL hw_resume: req=%b addr=%h expected req 1 addr 001008",
                     mem_bus.mem_req, mem_bus.mem_addr);
        end
        enable = 1'b0;
        ack_now();
        send_beats(16'hC008, 8, 0);
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n_we;
        do_reset();
        clear_logs();
        base_addr   = 24'h002000;
        frame_words = 24'd64;
        enable      = 1'b1;
        fill_pulse();
        wait_req(ok);
        ack_now();
        send_beats(16'hD000, 8, 0);
        wait_req(ok);
        tests_run++;
        if (ok !== 1'b1 || mem_bus.mem_addr !== 24'h002008) begin
            tests_failed++;
            $display("FAIL rstmid_second_addr: req=%b addr=%h expected req 1 addr 002008",
                     mem_bus.mem_req, mem_bus.mem_addr);
        end
        ack_now();
        clear_logs();
        send_beats(16'hD100, 5, 0);
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 16'hD105;
        reset              = 1'b1;
        tick();
        reset              = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        enable             = 1'b0;
        tests_run++;
        if ({fifo_we, busy, mem_bus.mem_req} !== 3'b000 || fifo_din !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: we/busy/req=%b din=%h expected 000 din 0000",
                     {fifo_we, busy, mem_bus.mem_req}, fifo_din);
        end
        n_we = 0;
        repeat (5) begin
            if (fifo_we !== 1'b0) n_we++;
            tick();
        end
        tests_run++;
        if (n_we != 0 || wr_data.size() != 5) begin
            tests_failed++;
            $display("FAIL rstmid_discard: late writes %0d total %0d expected 0 and 5",
                     n_we, wr_data.size());
        end
        enable = 1'b1;
        fill_pulse();
        wait_req(ok);
        tests_run++;
        if (ok !== 1'b1 || mem_bus.mem_addr !== 24'h002000) begin
            tests_failed++;
            $display("FAIL rstmid_restart_addr: req=%b addr=%h expected req 1 addr 002000",
                     mem_bus.mem_req, mem_bus.mem_addr);
        end
        enable = 1'b0;
        ack_now();
        send_beats(16'hD200, 8, 0);
        tick();
    endtask

    task automatic test_spurious();
        bit ok;
        do_reset();
        clear_logs();
        base_addr   = 24'h003000;
        frame_words = 24'd16;
        mem_bus.mem_rdata = 16'hEEEE;
        repeat (4) begin
            mem_bus.mem_rvalid = 1'b1;
            tick();
        end
        mem_bus.mem_rvalid = 1'b0;
        ack_now();
        tick();
        tests_run++;
        if ({busy, mem_bus.mem_req} !== 2'b00 || wr_data.size() != 0) begin
            tests_failed++;
            $display("FAIL spur_idle: busy/req=%b writes=%0d expected 00 and 0",
                     {busy, mem_bus.mem_req}, wr_data.size());
        end
        enable = 1'b1;
        fill_pulse();
        wait_req(ok);
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 16'hDEAD;
        tick();
        mem_bus.mem_rvalid = 1'b0;
        tests_run++;
        if (mem_bus.mem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL spur_req_hold: mem_req=%b expected 1", mem_bus.mem_req);
        end
        enable = 1'b0;
        ack_now();
        tests_run++;
        if (wr_data.size() != 0) begin
            tests_failed++;
            $display("FAIL spur_req_rvalid: writes=%0d expected 0", wr_data.size());
        end
        mem_bus.mem_ack = 1'b1;
        send_beats(16'hF000, 4, 0);
        tests_run++;
        if ({mem_bus.mem_req, busy} !== 2'b01) begin
            tests_failed++;
            $display("FAIL spur_data_ack: req/busy=%b expected 01", {mem_bus.mem_req, busy});
        end
        send_beats(16'hF004, 4, 0);
        mem_bus.mem_ack = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL spur_end: busy=%b expected 0", busy);
        end
        tick();
        tick();
        tests_run++;
        if (wr_data.size() != 8) begin
            tests_failed++;
            $display("FAIL spur_write_count: got %0d expected 8", wr_data.size());
        end
        for (int i = 0; i < 8 && i < wr_data.size(); i++) begin
            tests_run++;
            if (wr_data[i] !== 16'hF000 + 16'(i)) begin
                tests_failed++;
                $display("FAIL spur_write_%0d: got %h expected %h", i, wr_data[i], 16'hF000 + 16'(i));
            end
        end
    endtask

    task automatic test_gaps();
        bit ok;
        do_reset();
        clear_logs();
        base_addr   = 24'h004000;
        frame_words = 24'd16;
        enable      = 1'b1;
        fill_pulse();
        wait_req(ok);
        tests_run++;
        if (ok !== 1'b1 || mem_bus.mem_addr !== 24'h004000) begin
            tests_failed++;
            $display("FAIL gap_addr: req=%b addr=%h expected req 1 addr 004000",
                     mem_bus.mem_req, mem_bus.mem_addr);
        end
        enable = 1'b0;
        ack_now();
        send_beats(16'h5A00, 7, 1);
        tick();
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL gap_busy_after_7: busy=%b expected 1", busy);
        end
        send_beats(16'h5A07, 1, 0);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL gap_end_on_8: busy=%b expected 0", busy);
        end
        tick();
        tick();
        tests_run++;
        if (wr_data.size() != 8) begin
            tests_failed++;
            $display("FAIL gap_write_count: got %0d expected 8", wr_data.size());
        end
        for (int i = 0; i < 8 && i < wr_data.size(); i++) begin
            tests_run++;
            if (wr_data[i] !== 16'h5A00 + 16'(i) || wr_cyc[i] != beat_cyc[i] + 1) begin
                tests_failed++;
                $display("FAIL gap_write_%0d: data %h at cyc %0d expected %h at cyc %0d",
                         i, wr_data[i], wr_cyc[i], 16'h5A00 + 16'(i), beat_cyc[i] + 1);
            end
        end
    endtask

    initial begin
        reset              = 1'b1;
        enable             = 1'b0;
        buf_hw             = 1'b0;
        buf_lw             = 1'b0;
        base_addr          = '0;
        frame_words        = 24'd16;
        mem_bus.mem_ack    = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = '0;
        test_reset();
        test_basic_burst();
        test_wrap();
        test_hw_stop();
        test_reset_mid();
        test_spurious();
        test_gaps();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
